// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM states, CSR addresses,
// the CSR bundle carried between the controller and its write-value mux.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VECTOR,
        HANDLER,
        RETURN
    } trap_state_t;

    localparam logic [11:0] CSR_MTEVC  = 12'h305;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MIPD   = 12'h100;

    localparam logic [31:0] MIPD_BUSY = 32'd0;
    localparam logic [31:0] MIPD_DONE = 32'd1;

    typedef struct packed {
        logic [31:0] mtevc;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] mipd;
    } csr_set_t;

endpackage

// File: rtl/trap_csr_mux.sv
// Merges an optional single-field update into a full CSR bundle.
// Combinational, zero latency; no flow control of its own.
module trap_csr_mux
    import trap_pkg::*;
(
    input  csr_set_t    i_base,
    input  logic        i_upd,
    input  logic [11:0] i_addr,
    input  logic [31:0] i_data,
    output csr_set_t    o_csr,
    output logic        o_hit
);

    always_comb begin
        o_csr = i_base;
        o_hit = 1'b1;
        case (i_addr)
            CSR_MTEVC:  if (i_upd) o_csr.mtevc  = i_data;
            CSR_MCAUSE: if (i_upd) o_csr.mcause = i_data;
            CSR_MEPC:   if (i_upd) o_csr.mepc   = i_data;
            CSR_MTVAL:  if (i_upd) o_csr.mtval  = i_data;
            CSR_MIPD:   if (i_upd) o_csr.mipd   = i_data;
            default:    o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry/return sequencer: captures a trap, writes the CSRs, redirects the PC,
// then waits for mret; software CSR writes are accepted in IDLE and HANDLER only.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter bit VECTORED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_valid,
    output logic        trap_ready,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        sw_we,
    input  logic [11:0] sw_addr,
    input  logic [31:0] sw_data,
    output logic        sw_ready,
    output logic        sw_err,
    output logic        mret_err,
    input  logic [31:0] mtevc_q,
    input  logic [31:0] mcause_q,
    input  logic [31:0] mepc_q,
    input  logic [31:0] mtval_q,
    input  logic [31:0] mipd_q,
    output logic        csr_we,
    output logic [31:0] mtevc_d,
    output logic [31:0] mcause_d,
    output logic [31:0] mepc_d,
    output logic [31:0] mtval_d,
    output logic [31:0] mipd_d,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    trap_state_t r_state, w_next;
    logic [31:0] r_pc, r_cause, r_tval;

    logic        w_live, w_trap_acc, w_sw_acc;
    logic        w_trap_rdy, w_sw_rdy, w_mret_bad, w_we_fsm, w_redir;
    logic        w_upd, w_hit, w_unused;
    logic [11:0] w_addr;
    logic [31:0] w_data, w_rpc, w_tbase, w_vec_pc;
    csr_set_t    w_q, w_base, w_mux;

    assign w_q.mtevc  = mtevc_q;
    assign w_q.mcause = mcause_q;
    assign w_q.mepc   = mepc_q;
    assign w_q.mtval  = mtval_q;
    assign w_q.mipd   = mipd_q;

    // Interrupt vectors are spaced one word apart; overflow wraps silently.
    assign w_tbase  = {mtevc_q[31:2], 2'b00};
    assign w_vec_pc = (VECTORED && mcause_q[31]) ? (w_tbase + {mcause_q[29:0], 2'b00}) : w_tbase;
    assign w_unused = mcause_q[30];

    assign w_trap_acc = trap_valid && (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else begin
            r_state <= w_next;
            if (w_trap_acc) begin
                r_pc    <= trap_pc;
                r_cause <= trap_cause;
                r_tval  <= trap_tval;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_trap_rdy = 1'b0;
        w_sw_rdy   = 1'b0;
        w_mret_bad = mret_valid;
        w_we_fsm   = 1'b0;
        w_redir    = 1'b0;
        w_rpc      = '0;
        w_base     = w_q;
        w_upd      = 1'b0;
        w_addr     = sw_addr;
        w_data     = sw_data;
        case (r_state)
            IDLE: begin
                w_trap_rdy = 1'b1;
                w_sw_rdy   = ~trap_valid;
                if (trap_valid) w_next = SAVE;
            end
            SAVE: begin
                w_we_fsm      = 1'b1;
                w_base.mcause = r_cause;
                w_base.mepc   = r_pc;
                w_base.mtval  = r_tval;
                w_base.mipd   = MIPD_BUSY;
                w_next        = VECTOR;
            end
            VECTOR: begin
                w_redir = 1'b1;
                w_rpc   = w_vec_pc;
                w_next  = HANDLER;
            end
            HANDLER: begin
                w_mret_bad = 1'b0;
                w_sw_rdy   = ~mret_valid;
                if (mret_valid) w_next = RETURN;
            end
            RETURN: begin
                w_we_fsm = 1'b1;
                w_upd    = 1'b1;
                w_addr   = CSR_MIPD;
                w_data   = MIPD_DONE;
                w_redir  = 1'b1;
                w_rpc    = mepc_q;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
        w_sw_acc = sw_we && w_sw_rdy;
        if (w_sw_acc) w_upd = 1'b1;
    end

    trap_csr_mux u_mux (
        .i_base (w_base),
        .i_upd  (w_upd),
        .i_addr (w_addr),
        .i_data (w_data),
        .o_csr  (w_mux),
        .o_hit  (w_hit)
    );

    // Outputs are gated by reset so an in-flight sequence is dropped the instant rst rises.
    assign w_live         = ~rst;
    assign trap_ready     = w_live & w_trap_rdy;
    assign sw_ready       = w_live & w_sw_rdy;
    assign csr_we         = w_live & (w_we_fsm | (w_sw_acc & w_hit));
    assign sw_err         = w_live & w_sw_acc & ~w_hit;
    assign mret_err       = w_live & w_mret_bad;
    assign redirect_valid = w_live & w_redir;
    assign flush          = w_live & w_redir;
    assign redirect_pc    = w_live ? w_rpc : 32'h0;
    assign mtevc_d        = w_live ? w_mux.mtevc  : 32'h0;
    assign mcause_d       = w_live ? w_mux.mcause : 32'h0;
    assign mepc_d         = w_live ? w_mux.mepc   : 32'h0;
    assign mtval_d        = w_live ? w_mux.mtval  : 32'h0;
    assign mipd_d         = w_live ? w_mux.mipd   : 32'h0;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter VECTORED, default 0, meaning 0 = direct trap vectoring, 1 = vectored for interrupts (mcause[31]=1).
REQ-002 SHALL have port clk  input  1  the only clock; every register samples on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports trap_valid input 1, trap_ready output 1: trap request handshake.
REQ-005 SHALL have ports trap_pc, trap_cause, trap_tval, each input 32: faulting PC, cause code, trap value.
REQ-006 SHALL have port mret_valid  input  1  the trap handler is returning.
REQ-007 SHALL have ports sw_we input 1, sw_addr input 12, sw_data input 32, sw_ready output 1: software CSR write request.
REQ-008 SHALL have port sw_err  output  1  one-cycle pulse for an accepted write to an unmapped address.
REQ-009 SHALL have port mret_err  output  1  one-cycle pulse for mret_valid outside HANDLER.
REQ-010 SHALL have ports mtevc_q, mcause_q, mepc_q, mtval_q, mipd_q, each input 32: current CSR values.
REQ-011 SHALL have ports csr_we output 1 and mtevc_d, mcause_d, mepc_d, mtval_d, mipd_d, each output 32: the common write enable and the five write values.
REQ-012 SHALL have ports redirect_valid output 1, redirect_pc output 32, flush output 1: PC redirect and pipeline flush.

Function
REQ-013 SHALL implement states IDLE, SAVE, VECTOR, HANDLER, RETURN.
REQ-014 SHALL drive trap_ready=1 only in IDLE; trap_valid&trap_ready captures pc/cause/tval into internal registers and moves the FSM to SAVE.
REQ-015 SAVE SHALL last one cycle, with csr_we=1, mepc_d=captured pc, mcause_d=captured cause, mtval_d=captured tval, mipd_d=0, mtevc_d=mtevc_q; the next state is VECTOR.
REQ-016 VECTOR SHALL last one cycle, with redirect_valid=1 and flush=1; the next state is HANDLER.
REQ-017 In direct mode, redirect_pc SHALL be {mtevc_q[31:2],2'b00}.
REQ-018 With VECTORED=1 and mcause_q[31]=1, redirect_pc SHALL be {mtevc_q[31:2],2'b00} + (mcause_q[29:0]<<2), truncated to 32 bits (wrap-around permitted).
REQ-019 In HANDLER, mret_valid SHALL move the FSM to RETURN.
REQ-020 RETURN SHALL last one cycle, with csr_we=1, mipd_d=1, all other *_d equal to their *_q, redirect_valid=1, redirect_pc=mepc_q, flush=1; the next state is IDLE.
REQ-021 SHALL drive sw_ready=1 in IDLE and in HANDLER, except in a cycle where a trap is accepted or mret_valid=1 in HANDLER (trap and mret have priority over software writes).
REQ-022 An accepted write (sw_we&sw_ready) SHALL assert csr_we in the same cycle: the field selected by sw_addr (0x305, 0x342, 0x341, 0x343, 0x100) takes sw_data, all other fields take their *_q.
REQ-023 An accepted write to any other sw_addr SHALL keep csr_we=0 and pulse sw_err for one cycle.
REQ-024 mret_valid outside HANDLER SHALL be ignored and SHALL pulse mret_err for one cycle.
REQ-025 trap_valid outside IDLE SHALL be held off (trap_ready=0) with no state change; the requester keeps its request asserted.
REQ-026 A write to mepc in HANDLER SHALL be visible in a following RETURN, so that a later mret returns to the new value.
REQ-027 csr_we SHALL be 0 in every cycle not covered by REQ-015, REQ-020 and REQ-022.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE and clear csr_we, redirect_valid, flush, sw_err, mret_err, sw_ready and trap_ready; all *_d and redirect_pc outputs SHALL be 0.
REQ-029 trap_ready and sw_ready SHALL rise in the first cycle after rst deasserts.
REQ-030 A reset in the middle of any sequence SHALL abandon it without a partial CSR write or redirect.

Structure
REQ-031 A shared package trap_pkg SHALL hold the state enum, the CSR address constants (0x305, 0x342, 0x341, 0x343, 0x100) and the MIPD_BUSY=0 / MIPD_DONE=1 constants.
REQ-032 A single sub-module trap_csr_mux SHALL merge a one-field update into the five *_d values; it is combinational and shared by the SAVE, RETURN and software-write paths.

Verification
REQ-033 Scenario: trap_valid with pc=0x100, cause=2, tval=0xDEAD, mtevc_q=0x1003 -> SAVE writes mepc 0x100, mcause 2, mtval 0xDEAD, mipd 0; the next cycle redirect_pc=0x1000 with flush=1.
REQ-034 Scenario: VECTORED=1, mtevc_q=0x2000, mcause_q=0x80000003 -> redirect_pc=0x200C.
REQ-035 Scenario: in HANDLER, sw write of 0x344 to 0x341, then mret -> RETURN gives redirect_pc=0x344 and mipd_d=1.
REQ-036 Scenario: trap_valid and sw_we in the same IDLE cycle -> trap accepted, sw_ready=0, no software write that cycle.
REQ-037 Scenario: sw_addr=0x7FF -> sw_err pulse and csr_we=0; mret_valid in IDLE -> mret_err pulse and no redirect.
REQ-038 Scenario: rst asserted during SAVE -> csr_we=0 at once; trap_ready=1 one cycle after release.
